// File: rtl/cmos_frame_window.sv
// OV7670 capture stage: waits for init, skips settling frames, packs byte pairs to RGB565 and crops to the LCD window.
// Optional build macro CMOS_FRAME_TESTPAT_EN replaces pix_data with 8 vertical colour bars.
`timescale 1ns/1ps
module cmos_frame_window #(
  parameter int SRC_H       = 640,
  parameter int WIN_H       = 480,
  parameter int WIN_V       = 272,
  parameter int H_OFF       = 80,
  parameter int V_OFF       = 104,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic        pix_we,
  output logic [15:0] pix_data,
  output logic        frame_valid,
  output logic [7:0]  frame_cnt,
  output logic        line_err
);

  typedef enum logic [1:0] {IDLE, SKIP, WAIT_VS, ACTIVE} state_t;

  localparam logic [10:0] X_SRC  = 11'(SRC_H);
  localparam logic [10:0] X_LO   = 11'(H_OFF);
  localparam logic [10:0] X_HI   = 11'(H_OFF + WIN_H);
  localparam logic [9:0]  Y_LO   = 10'(V_OFF);
  localparam logic [9:0]  Y_HI   = 10'(V_OFF + WIN_V);
  localparam logic [7:0]  SKIP_N = 8'(SKIP_FRAMES);

  state_t      state, state_nxt;
  logic        s_vs, s_hr, s_vs_d, s_hr_d;
  logic [7:0]  s_d;
  logic        vs_fall, vs_rise, hr_fall;
  logic [7:0]  skip_cnt;
  logic        phase;
  logic [7:0]  hi_byte;
  logic [10:0] x;
  logic [9:0]  y;
  logic        byte_en, in_win;
  logic [15:0] pix_word;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_vs   <= 1'b0;
      s_hr   <= 1'b0;
      s_d    <= '0;
      s_vs_d <= 1'b0;
      s_hr_d <= 1'b0;
    end else begin
      s_vs   <= cmos_vsync;
      s_hr   <= cmos_href;
      s_d    <= cmos_data;
      s_vs_d <= s_vs;
      s_hr_d <= s_hr;
    end
  end

  assign vs_fall = s_vs_d & ~s_vs;
  assign vs_rise = ~s_vs_d & s_vs;
  assign hr_fall = s_hr_d & ~s_hr;

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (init_done) state_nxt = SKIP;
      SKIP:    if (skip_cnt == SKIP_N) state_nxt = WAIT_VS;
      WAIT_VS: if (vs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (vs_rise) state_nxt = WAIT_VS;
      default: state_nxt = IDLE;
    endcase
    if (!init_done) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Skip counter only lives in SKIP, so leaving it (including via init_done=0) discards progress.
  always_ff @(posedge clk) begin
    if (rst || state != SKIP) skip_cnt <= '0;
    else if (vs_rise)         skip_cnt <= skip_cnt + 8'd1;
  end

  // A rising VSYNC aborts the line immediately, even for a byte already registered.
  assign byte_en = (state == ACTIVE) && s_hr && !vs_rise;
  assign in_win  = (x >= X_LO) && (x < X_HI) && (x < X_SRC) && (y >= Y_LO) && (y < Y_HI);

`ifdef CMOS_FRAME_TESTPAT_EN
  localparam int BAR_W = (WIN_H / 8 > 0) ? WIN_H / 8 : 1;
  logic [10:0] win_x, bar_idx;
  assign win_x   = x - X_LO;
  assign bar_idx = win_x / 11'(BAR_W);
  always_comb begin
    pix_word = 16'h0000;
    case (bar_idx[2:0])
      3'd0: pix_word = 16'hFFFF;
      3'd1: pix_word = 16'hFFE0;
      3'd2: pix_word = 16'h07FF;
      3'd3: pix_word = 16'h07E0;
      3'd4: pix_word = 16'hF81F;
      3'd5: pix_word = 16'hF800;
      3'd6: pix_word = 16'h001F;
      default: pix_word = 16'h0000;
    endcase
  end
`else
  assign pix_word = {hi_byte, s_d};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= 1'b0;
      hi_byte  <= '0;
      x        <= '0;
      y        <= '0;
      pix_we   <= 1'b0;
      pix_data <= '0;
      line_err <= 1'b0;
    end else begin
      pix_we <= 1'b0;
      if (vs_fall) begin
        // Frame start wins over a coincident HREF fall, so y starts at 0.
        phase    <= 1'b0;
        x        <= '0;
        y        <= '0;
        line_err <= 1'b0;
      end else if (state == ACTIVE) begin
        if (hr_fall) begin
          phase <= 1'b0;
          x     <= '0;
          y     <= y + 10'd1;
          if (phase || x != X_SRC) line_err <= 1'b1;
        end else if (byte_en) begin
          phase <= ~phase;
          if (!phase) begin
            hi_byte <= s_d;
          end else begin
            if (x != X_SRC) x <= x + 11'd1;
            if (in_win) begin
              pix_we   <= 1'b1;
              pix_data <= pix_word;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_valid <= (state_nxt == ACTIVE);
      // Only a frame that delivered every window line counts as completed.
      if (state == ACTIVE && vs_rise && state_nxt == WAIT_VS && y >= Y_HI)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cmos_frame_window.sv
// Directed bench for cmos_frame_window on a scaled sensor geometry: frame-level vector table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_cmos_frame_window;

  localparam int SRC_H = 24, WIN_H = 16, WIN_V = 4, H_OFF = 4, V_OFF = 3, SKIP_FRAMES = 2;
  localparam int LINES = 10;
  localparam int ABORT_B = 14;
  localparam int NROWS = 12;

  logic        clk = 1'b0;
  logic        rst, init_done, cmos_vsync, cmos_href;
  logic [7:0]  cmos_data;
  logic        pix_we, frame_valid, line_err;
  logic [15:0] pix_data;
  logic [7:0]  frame_cnt;

  int checks = 0, errors = 0;
  int cyc = 0;
  int pix_in_frame = 0, first_cyc = -1, cd_cyc = 0, b2b = 0;
  logic [15:0] first_data = '0;
  logic prev_we = 1'b0;

  typedef struct {
    bit init;
    bit pulse;
    int mod_line;
    int mod_delta;
    int abort_line;
    int exp_pix;
    int exp_cnt;
    bit exp_err;
    bit exp_fv_mid;
  } frame_t;

  frame_t tbl[NROWS];

  cmos_frame_window #(
    .SRC_H(SRC_H), .WIN_H(WIN_H), .WIN_V(WIN_V),
    .H_OFF(H_OFF), .V_OFF(V_OFF), .SKIP_FRAMES(SKIP_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
    .pix_we(pix_we), .pix_data(pix_data), .frame_valid(frame_valid),
    .frame_cnt(frame_cnt), .line_err(line_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] bval(input int l, input int b);
    if (l == V_OFF && b == 2*H_OFF)     return 8'hAB;
    if (l == V_OFF && b == 2*H_OFF + 1) return 8'hCD;
    return 8'(l*37 + b*11 + 5);
  endfunction

  function automatic logic [15:0] exp_pixel(input int idx);
    int l, c;
    l = V_OFF + idx / WIN_H;
    c = H_OFF + idx % WIN_H;
`ifdef CMOS_FRAME_TESTPAT_EN
    case ((c - H_OFF) / (WIN_H / 8))
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
`else
    return {bval(l, 2*c), bval(l, 2*c + 1)};
`endif
  endfunction

  // Pixel scoreboard: window pixels must arrive in raster order, never back to back.
  always @(negedge clk) begin
    if (pix_we) begin
      if (prev_we) b2b++;
      if (pix_in_frame == 0) begin
        first_cyc  = cyc;
        first_data = pix_data;
      end
      check($sformatf("pix_data[%0d]", pix_in_frame), 32'(pix_data), 32'(exp_pixel(pix_in_frame)));
      pix_in_frame++;
    end
    prev_we = pix_we;
  end

  task automatic run_frame(input int row, input frame_t r);
    int nb;
    bit aborted;
    logic fv_mid;
    aborted = 1'b0;
    fv_mid  = 1'b0;
    if (r.pulse) begin
      init_done = 1'b0;
      tick(3);
    end
    init_done = r.init;
    tick(3);
    pix_in_frame = 0;
    first_cyc    = -1;
    cmos_vsync   = 1'b0;
    tick(3);
    for (int l = 0; l < LINES; l++) begin
      nb = 2*SRC_H + ((l == r.mod_line) ? r.mod_delta : 0);
      for (int b = 0; b < nb; b++) begin
        if (l == r.abort_line && b == ABORT_B) cmos_vsync = 1'b1;
        cmos_href = 1'b1;
        cmos_data = bval(l, b);
        if (l == V_OFF && b == 2*H_OFF + 1) cd_cyc = cyc;
        tick();
        if (l == r.abort_line && b == ABORT_B)
          check("fv_abort_hold", 32'(frame_valid), 32'd1);
        if (l == r.abort_line && b == ABORT_B + 1) begin
          check("fv_abort_fall", 32'(frame_valid), 32'd0);
          aborted = 1'b1;
          break;
        end
      end
      cmos_href = 1'b0;
      cmos_data = 8'h00;
      tick(3);
      if (l == 0) fv_mid = frame_valid;
      if (aborted) break;
    end
    cmos_vsync = 1'b1;
    tick(6);
    check($sformatf("row%0d pix_count", row), 32'(pix_in_frame), 32'(r.exp_pix));
    check($sformatf("row%0d frame_cnt", row), 32'(frame_cnt), 32'(r.exp_cnt));
    check($sformatf("row%0d line_err", row), 32'(line_err), 32'(r.exp_err));
    check($sformatf("row%0d fv_mid", row), 32'(fv_mid), 32'(r.exp_fv_mid));
    check($sformatf("row%0d fv_end", row), 32'(frame_valid), 32'd0);
    if (r.exp_pix > 0) begin
      check($sformatf("row%0d latency", row), 32'(first_cyc - cd_cyc), 32'd2);
`ifdef CMOS_FRAME_TESTPAT_EN
      check($sformatf("row%0d first_pix", row), 32'(first_data), 32'h0000FFFF);
`else
      check($sformatf("row%0d first_pix", row), 32'(first_data), 32'h0000ABCD);
`endif
    end
  endtask

  initial begin
    //          init pulse mod_l delta abort pix cnt err fv
    tbl[0]  = '{0, 0, -1,  0, -1,  0, 0, 0, 0};
    tbl[1]  = '{0, 0, -1,  0, -1,  0, 0, 0, 0};
    tbl[2]  = '{0, 0, -1,  0, -1,  0, 0, 0, 0};
    tbl[3]  = '{1, 0, -1,  0, -1,  0, 0, 0, 0};
    tbl[4]  = '{1, 0, -1,  0, -1,  0, 0, 0, 0};
    tbl[5]  = '{1, 0, -1,  0, -1, 64, 1, 0, 1};
    tbl[6]  = '{1, 0,  4, -1, -1, 64, 2, 1, 1};
    tbl[7]  = '{1, 0,  5,  4, -1, 64, 3, 0, 1};
    tbl[8]  = '{1, 0, -1,  0,  5, 35, 3, 0, 1};
    tbl[9]  = '{1, 1, -1,  0, -1,  0, 3, 0, 0};
    tbl[10] = '{1, 0, -1,  0, -1,  0, 3, 0, 0};
    tbl[11] = '{1, 0, -1,  0, -1, 64, 4, 0, 1};

    rst        = 1'b1;
    init_done  = 1'b0;
    cmos_vsync = 1'b1;
    cmos_href  = 1'b0;
    cmos_data  = 8'h00;
    tick(3);
    check("rst pix_we", 32'(pix_we), 32'd0);
    check("rst pix_data", 32'(pix_data), 32'd0);
    check("rst frame_valid", 32'(frame_valid), 32'd0);
    check("rst frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst line_err", 32'(line_err), 32'd0);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < NROWS; i++) run_frame(i, tbl[i]);

    check("no back-to-back pix_we", 32'(b2b), 32'd0);

    // Reset must override an ongoing frame with init_done still high.
    cmos_vsync = 1'b0;
    tick(4);
    rst = 1'b1;
    tick();
    check("mid-run rst frame_cnt", 32'(frame_cnt), 32'd0);
    check("mid-run rst frame_valid", 32'(frame_valid), 32'd0);
    rst = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
